mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
- Consumes the free-running pseudo-random words produced by the team's LFSR generators and turns them into game events for Whack-a-Mole.
- Picks which hole pops up, how long the mole stays up, and the gap before the next mole.
- Checks player hits against the live mole and keeps the score and miss counters.
- Sits between the LFSR block and the display and button logic; all timing advances on an external game tick.

Parameters:
- NUM_HOLES, 8: number of holes. Power of 2; hole index width HW = log2(NUM_HOLES).
- RAND_W, 10: width of rand_in. Must be at least max(HW, 8).
- MIN_UP, 4: minimum mole-up time in ticks. Must be at least 1.
- MIN_GAP, 2: minimum gap between moles in ticks. Must be at least 1.
- MAX_MISS, 3: number of misses that ends the game. Must be between 1 and 255.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- restart  in  1  synchronous active-high reset.
- tick  in  1  single-cycle game-time enable.
- rand_in  in  RAND_W  current LFSR output, sampled only at the load points defined below.
- start  in  1  single-cycle start-game pulse.
- hit_valid  in  1  single-cycle player-hit strobe.
- hit_hole  in  HW  hole index of the hit.
- mole_mask  out  NUM_HOLES  one-hot active mole, or all zeros when no mole is up.
- score  out  8  hit count, saturating at 255.
- miss_count  out  8  expired-mole count.
- busy  out  1  high in the GAP and UP states.
- game_over  out  1  high in the OVER state.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, clk; reset restart is synchronous and active-high.
  - restart overrides everything on the next clk edge, including mid-game.
  - After reset: state IDLE, mole_mask 0, score 0, miss_count 0, busy 0, game_over 0, last_hole 0, all counters 0.
- Output timing: all outputs are registered. They reflect the new state in the cycle after the transition edge.
- States: IDLE, GAP, UP, OVER.
- IDLE:
  - On start: clear score and miss_count, load gap_cnt = MIN_GAP + rand_in[3:0], go to GAP.
- GAP:
  - On tick with gap_cnt > 1: decrement gap_cnt.
  - On tick with gap_cnt == 1: go to UP. Sample rand_in once:
    - h = rand_in[HW-1:0]. If h == last_hole, use h = (h+1) mod NUM_HOLES, so the same hole never appears twice in a row.
    - hole = h; last_hole = h.
    - up_cnt = MIN_UP + rand_in[RAND_W-1:RAND_W-4].
  - The mole is therefore visible for exactly the loaded number of ticks. The same load-and-count rule applies to gap_cnt.
- UP:
  - mole_mask = 1 << hole.
  - Correct hit (hit_valid and hit_hole == hole): score++ (saturating at 255), load gap_cnt from rand_in[3:0] as in IDLE, go to GAP.
  - Wrong-hole hit, or hit_valid outside UP: ignored, with no penalty.
  - Tick with up_cnt > 1: decrement up_cnt.
  - Tick with up_cnt == 1 (expiry): miss_count++.
    - If the new miss_count == MAX_MISS, go to OVER.
    - Otherwise load gap_cnt and go to GAP.
  - Correct hit in the same cycle as the expiring tick: the hit wins. Score increments; miss_count is unchanged.
- OVER:
  - mole_mask 0, game_over 1; score and miss_count hold.
  - On start: clear the counters, load gap_cnt, go to GAP.
- start received in GAP or UP is ignored.
- tick and rand_in are ignored in IDLE and OVER.
- Width rule: each load is a plain unsigned add, sized to avoid overflow (counter width covers MIN_UP+15 and MIN_GAP+15).

Test Plan:
- restart; rand_in = 10'h000 held; start -> GAP for 2 ticks, then mole_mask = 8'b0000_0010 (hole 0 repeats last_hole 0, bumped to 1); busy = 1.
- Continuing: hit_valid with hit_hole = 1 -> score = 1, mole_mask = 0 the next cycle, state GAP; hit_hole = 3 instead -> no change.
- rand_in = 0, no hits -> each mole expires after 4 ticks; after the 3rd expiry miss_count = 3, game_over = 1, mole_mask = 0, busy = 0; later ticks change nothing; start -> score = 0, miss_count = 0, busy = 1.
- Correct hit asserted in the same cycle as the tick with up_cnt == 1 -> score +1, miss_count unchanged.
- rand_in = 10'h3C5 at the GAP->UP load -> hole 5, mole visible for exactly 19 ticks; the following gap load with the same value = 7 ticks.
- restart pulsed during UP -> next cycle mole_mask = 0, score = 0, miss_count = 0, state IDLE; start pulsed during UP (no restart) -> ignored.

Source files
------------

// File: rtl/mole_scheduler.sv
// Whack-a-Mole event scheduler: turns LFSR words into mole positions and
// up/gap durations, checks player hits and tracks score and misses.
module mole_scheduler #(
  parameter int NUM_HOLES = 8,
  parameter int RAND_W    = 10,
  parameter int MIN_UP    = 4,
  parameter int MIN_GAP   = 2,
  parameter int MAX_MISS  = 3,
  localparam int HW       = $clog2(NUM_HOLES)
) (
  input  logic                 clk,
  input  logic                 restart,
  input  logic                 tick,
  input  logic [RAND_W-1:0]    rand_in,
  input  logic                 start,
  input  logic                 hit_valid,
  input  logic [HW-1:0]        hit_hole,
  output logic [NUM_HOLES-1:0] mole_mask,
  output logic [7:0]           score,
  output logic [7:0]           miss_count,
  output logic                 busy,
  output logic                 game_over
);

  localparam int CNT_MAX = ((MIN_UP > MIN_GAP) ? MIN_UP : MIN_GAP) + 15;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]          up_cnt_q, up_cnt_d;
  logic [HW-1:0]          hole_q, hole_d;
  logic [HW-1:0]          last_hole_q, last_hole_d;
  logic [7:0]             score_q, score_d;
  logic [7:0]             miss_q, miss_d;
  logic [NUM_HOLES-1:0]   mask_q, mask_d;
  logic                   busy_q, busy_d;
  logic                   over_q, over_d;

  logic [CW-1:0]          gap_load;
  logic [CW-1:0]          up_load;
  logic [HW-1:0]          hole_pick;
  logic [7:0]             miss_inc;

  // Load values and next-hole selection derived from the current LFSR word.
  always_comb begin
    gap_load  = CW'(MIN_GAP) + CW'(rand_in[3:0]);
    up_load   = CW'(MIN_UP) + CW'(rand_in[RAND_W-1 -: 4]);
    hole_pick = rand_in[HW-1:0];
    if (hole_pick == last_hole_q) begin
      hole_pick = hole_pick + HW'(1);
    end
    miss_inc  = miss_q + 8'd1;
  end

  // Next-state logic; registered outputs are decoded from the next state so
  // they line up with the new state one cycle after the transition edge.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    up_cnt_d    = up_cnt_q;
    hole_d      = hole_q;
    last_hole_d = last_hole_q;
    score_d     = score_q;
    miss_d      = miss_q;

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          score_d   = '0;
          miss_d    = '0;
          gap_cnt_d = gap_load;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q > CW'(1)) begin
            gap_cnt_d = gap_cnt_q - CW'(1);
          end else begin
            hole_d      = hole_pick;
            last_hole_d = hole_pick;
            up_cnt_d    = up_load;
            state_d     = UP;
          end
        end
      end
      UP: begin
        // A correct hit takes priority over an expiring tick in the same cycle.
        if (hit_valid && (hit_hole == hole_q)) begin
          score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          gap_cnt_d = gap_load;
          state_d   = GAP;
        end else if (tick) begin
          if (up_cnt_q > CW'(1)) begin
            up_cnt_d = up_cnt_q - CW'(1);
          end else begin
            miss_d = miss_inc;
            if (miss_inc == 8'(MAX_MISS)) begin
              state_d = OVER;
            end else begin
              gap_cnt_d = gap_load;
              state_d   = GAP;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mask_d = (state_d == UP) ? (NUM_HOLES'(1) << hole_d) : '0;
    busy_d = (state_d == GAP) || (state_d == UP);
    over_d = (state_d == OVER);
  end

  // State and output registers with synchronous restart.
  always_ff @(posedge clk) begin
    if (restart) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      up_cnt_q    <= '0;
      hole_q      <= '0;
      last_hole_q <= '0;
      score_q     <= '0;
      miss_q      <= '0;
      mask_q      <= '0;
      busy_q      <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      up_cnt_q    <= up_cnt_d;
      hole_q      <= hole_d;
      last_hole_q <= last_hole_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
      mask_q      <= mask_d;
      busy_q      <= busy_d;
      over_q      <= over_d;
    end
  end

  assign mole_mask  = mask_q;
  assign score      = score_q;
  assign miss_count = miss_q;
  assign busy       = busy_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Testbench for mole_scheduler: reference model feeds an expected-output
// queue each driven cycle; DUT outputs are popped and compared after the edge.
module tb_mole_scheduler;

  localparam int NH = 8;

  logic          clk = 1'b0;
  logic          restart = 1'b1;
  logic          tick = 1'b0;
  logic [9:0]    rand_in = '0;
  logic          start = 1'b0;
  logic          hit_valid = 1'b0;
  logic [2:0]    hit_hole = '0;
  logic [NH-1:0] mole_mask;
  logic [7:0]    score;
  logic [7:0]    miss_count;
  logic          busy;
  logic          game_over;

  mole_scheduler #(
    .NUM_HOLES(8),
    .RAND_W   (10),
    .MIN_UP   (4),
    .MIN_GAP  (2),
    .MAX_MISS (3)
  ) dut (
    .clk       (clk),
    .restart   (restart),
    .tick      (tick),
    .rand_in   (rand_in),
    .start     (start),
    .hit_valid (hit_valid),
    .hit_hole  (hit_hole),
    .mole_mask (mole_mask),
    .score     (score),
    .miss_count(miss_count),
    .busy      (busy),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] score;
    logic [7:0] miss;
    logic       busy;
    logic       over;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (0 idle, 1 gap, 2 up, 3 over).
  int m_state = 0;
  int m_gap   = 0;
  int m_up    = 0;
  int m_hole  = 0;
  int m_last  = 0;
  int m_score = 0;
  int m_miss  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_step();
    int r;
    int h;
    exp_t e;
    r = int'(rand_in);
    if (restart) begin
      m_state = 0; m_gap = 0; m_up = 0; m_hole = 0; m_last = 0; m_score = 0; m_miss = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (start) begin
        m_score = 0; m_miss = 0; m_gap = 2 + (r % 16); m_state = 1;
      end
    end else if (m_state == 1) begin
      if (tick) begin
        if (m_gap > 1) m_gap = m_gap - 1;
        else begin
          h = r % NH;
          if (h == m_last) h = (h + 1) % NH;
          m_hole = h; m_last = h;
          m_up = 4 + (r / 64);
          m_state = 2;
        end
      end
    end else begin
      if (hit_valid && int'(hit_hole) == m_hole) begin
        if (m_score < 255) m_score = m_score + 1;
        m_gap = 2 + (r % 16);
        m_state = 1;
      end else if (tick) begin
        if (m_up > 1) m_up = m_up - 1;
        else begin
          m_miss = m_miss + 1;
          if (m_miss == 3) m_state = 3;
          else begin
            m_gap = 2 + (r % 16);
            m_state = 1;
          end
        end
      end
    end
    e.mask  = (m_state == 2) ? 8'(1 << m_hole) : 8'h00;
    e.score = 8'(m_score);
    e.miss  = 8'(m_miss);
    e.busy  = (m_state == 1 || m_state == 2);
    e.over  = (m_state == 3);
    exp_q.push_back(e);
  endtask

  // One clock: inputs are already driven; model predicts, DUT is compared
  // #1 after the edge, then single-cycle strobes are dropped.
  task automatic cyc(input logic t, input logic s, input logic hv, input logic [2:0] hh);
    exp_t e;
    tick = t; start = s; hit_valid = hv; hit_hole = hh;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("mole_mask", 32'(mole_mask), 32'(e.mask));
      check_eq("score", 32'(score), 32'(e.score));
      check_eq("miss_count", 32'(miss_count), 32'(e.miss));
      check_eq("busy", 32'(busy), 32'(e.busy));
      check_eq("game_over", 32'(game_over), 32'(e.over));
    end
    tick = 1'b0; start = 1'b0; hit_valid = 1'b0;
  endtask

  initial begin
    int n;
    int sc;
    int ms;

    // Reset.
    restart = 1'b1;
    rand_in = 10'h000;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    restart = 1'b0;
    check_eq("reset_mask", 32'(mole_mask), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);

    // Start, two gap ticks, hole 0 bumped to 1.
    cyc(0, 1, 0, 0);
    check_eq("start_busy", 32'(busy), 32'h1);
    cyc(1, 0, 0, 0);
    check_eq("gap_tick1_mask", 32'(mole_mask), 32'h0);
    cyc(1, 0, 0, 0);
    check_eq("first_mole_mask", 32'(mole_mask), 32'h02);
    check_eq("first_mole_busy", 32'(busy), 32'h1);

    // Wrong-hole hit ignored, correct hit scores.
    cyc(0, 0, 1, 3'd3);
    check_eq("wrong_hit_score", 32'(score), 32'd0);
    check_eq("wrong_hit_mask", 32'(mole_mask), 32'h02);
    cyc(0, 0, 1, 3'd1);
    check_eq("hit_score", 32'(score), 32'd1);
    check_eq("hit_mask", 32'(mole_mask), 32'h0);
    check_eq("hit_busy", 32'(busy), 32'h1);

    // No hits: three expiries end the game.
    n = 0;
    while (!game_over && n < 200) begin
      cyc(1, 0, 0, 0);
      n++;
    end
    // 2 gap ticks + 4 up ticks per mole, three moles.
    check_eq("ticks_to_over", 32'(n), 32'd18);
    check_eq("over_miss", 32'(miss_count), 32'd3);
    check_eq("over_flag", 32'(game_over), 32'h1);
    check_eq("over_mask", 32'(mole_mask), 32'h0);
    check_eq("over_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 3'(i));
    check_eq("over_hold_score", 32'(score), 32'd1);
    check_eq("over_hold_miss", 32'(miss_count), 32'd3);

    // Restart the game from OVER.
    cyc(0, 1, 0, 0);
    check_eq("restart_score", 32'(score), 32'd0);
    check_eq("restart_miss", 32'(miss_count), 32'd0);
    check_eq("restart_busy", 32'(busy), 32'h1);

    // Hit in the same cycle as the expiring tick.
    n = 0;
    while (m_state != 2 && n < 50) begin cyc(1, 0, 0, 0); n++; end
    while (m_up > 1 && n < 100) begin cyc(1, 0, 0, 0); n++; end
    check_eq("reach_expiry_bound", 32'(n < 100), 32'd1);
    sc = int'(score);
    ms = int'(miss_count);
    cyc(1, 0, 1, 3'(m_hole));
    check_eq("race_score", 32'(score), 32'(sc + 1));
    check_eq("race_miss", 32'(miss_count), 32'(ms));
    check_eq("race_mask", 32'(mole_mask), 32'h0);

    // 10'h3C5 at the load: hole 5, 19 ticks up, 7 ticks gap.
    n = 0;
    while (m_gap > 1 && n < 50) begin cyc(1, 0, 0, 0); n++; end
    rand_in = 10'h3C5;
    cyc(1, 0, 0, 0);
    check_eq("hole5_mask", 32'(mole_mask), 32'h20);
    n = 0;
    while (mole_mask != '0 && n < 100) begin cyc(1, 0, 0, 0); n++; end
    check_eq("up_ticks_19", 32'(n), 32'd19);
    n = 0;
    while (mole_mask == '0 && n < 100) begin cyc(1, 0, 0, 0); n++; end
    check_eq("gap_ticks_7", 32'(n), 32'd7);
    check_eq("next_hole6", 32'(mole_mask), 32'h40);

    // start during UP ignored; restart during UP clears.
    cyc(0, 1, 0, 0);
    check_eq("start_in_up_mask", 32'(mole_mask), 32'h40);
    restart = 1'b1;
    cyc(1, 1, 1, 3'd6);
    restart = 1'b0;
    check_eq("midgame_rst_mask", 32'(mole_mask), 32'h0);
    check_eq("midgame_rst_score", 32'(score), 32'd0);
    check_eq("midgame_rst_miss", 32'(miss_count), 32'd0);
    check_eq("midgame_rst_busy", 32'(busy), 32'h0);

    // Idle ignores ticks.
    cyc(1, 0, 0, 0);
    check_eq("idle_tick_busy", 32'(busy), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      restart = ($urandom_range(0, 299) == 0);
      rand_in = 10'($urandom);
      cyc($urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 5) == 0,
          ($urandom_range(0, 1) == 0) ? 3'(m_hole) : 3'($urandom_range(0, 7)));
    end
    restart = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
